// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline: load-use and HI/LO stalls, branch flushes, EX forwarding.
// Optional macro FORWARDING_EN enables EX operand forwarding; without it, RAW hazards on EX/MEM writers stall instead.
module hazard_ctrl_unit #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 32,
  parameter int CNT_W             = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_hilo,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              mdu_start,
  input  logic [REG_AW-1:0] mem_wr_reg,
  input  logic [REG_AW-1:0] wb_wr_reg,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy,
  output logic              dbg_state
);

  typedef enum logic {ST_RUN = 1'b0, ST_LOAD_WAIT = 1'b1} state_t;

  localparam logic [2:0]       LCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] MCNT_INIT = CNT_W'(MDU_LATENCY);

  state_t           state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic load_hit, flush_req, mdu_active, mdu_stall, raw_stall, load_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  // Register 0 is hard-wired, so a zero destination never produces a match.
  assign ex_rs_hit  = id_uses_rs && (ex_wr_reg != '0)  && (id_rs == ex_wr_reg);
  assign ex_rt_hit  = id_uses_rt && (ex_wr_reg != '0)  && (id_rt == ex_wr_reg);
  assign mem_rs_hit = id_uses_rs && (mem_wr_reg != '0) && (id_rs == mem_wr_reg);
  assign mem_rt_hit = id_uses_rt && (mem_wr_reg != '0) && (id_rt == mem_wr_reg);

  assign load_hit   = ex_mem_to_reg && (ex_rs_hit || ex_rt_hit);
  assign flush_req  = ex_branch_taken || ex_jump;
  assign mdu_active = (mcnt_q != '0);
  assign mdu_stall  = id_uses_hilo && (mdu_active || mdu_start);

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (mem_reg_write && (mem_wr_reg != '0) && (mem_wr_reg == src)) return 2'b10;
    else if (wb_reg_write && (wb_wr_reg != '0) && (wb_wr_reg == src)) return 2'b01;
    else return 2'b00;
  endfunction

  assign raw_stall = 1'b0;
  assign fwd_a_sel = fwd_sel(ex_rs);
  assign fwd_b_sel = fwd_sel(ex_rt);

  logic unused_nofwd;
  assign unused_nofwd = ^{ex_reg_write, mem_rs_hit, mem_rt_hit};
`else
  // WB is covered by the register file writing before it is read.
  assign raw_stall = (ex_reg_write && (ex_rs_hit || ex_rt_hit)) ||
                     (mem_reg_write && (mem_rs_hit || mem_rt_hit));
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  logic unused_fwd;
  assign unused_fwd = ^{ex_rs, ex_rt, wb_wr_reg, wb_reg_write};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      lcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    mcnt_d  = mcnt_q;
    // A flush squashes the stalled consumer, so any pending load wait is abandoned.
    if (flush_req) begin
      state_d = ST_RUN;
      lcnt_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_hit && (LOAD_STALL_CYCLES > 1)) begin
            state_d = ST_LOAD_WAIT;
            lcnt_d  = LCNT_INIT;
          end
        end
        ST_LOAD_WAIT: begin
          lcnt_d = lcnt_q - 3'd1;
          if (lcnt_q == 3'd1) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          lcnt_d  = '0;
        end
      endcase
    end
    // The MDU op is older than any branch in EX, so flush leaves it running.
    if (mdu_start)       mcnt_d = MCNT_INIT;
    else if (mdu_active) mcnt_d = mcnt_q - 1'b1;
  end

  always_comb begin
    load_stall = (state_q == ST_LOAD_WAIT) || load_hit;
    stall      = !rst && !flush_req && (load_stall || mdu_stall || raw_stall);
    flush      = !rst && flush_req;
    fwd_a      = rst ? 2'b00 : fwd_a_sel;
    fwd_b      = rst ? 2'b00 : fwd_b_sel;
    mdu_busy   = !rst && mdu_active;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (1 and 3 load bubbles, MDU latency 4) against a bubble-count model.
module tb_hazard_ctrl_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic id_uses_rs, id_uses_rt, id_uses_hilo, ex_reg_write, ex_mem_to_reg;
  logic ex_branch_taken, ex_jump, mdu_start, mem_reg_write, wb_reg_write;

  logic stall_a, flush_a, busy_a, dbg_a, stall_b, flush_b, busy_b, dbg_b;
  logic [1:0] fa_a, fb_a, fa_b, fb_b;

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL_CYCLES(1), .MDU_LATENCY(LAT), .CNT_W(6)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mdu_start(mdu_start),
    .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .stall(stall_a), .flush(flush_a), .fwd_a(fa_a),
    .fwd_b(fb_a), .mdu_busy(busy_a), .dbg_state(dbg_a));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL_CYCLES(3), .MDU_LATENCY(LAT), .CNT_W(6)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mdu_start(mdu_start),
    .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .stall(stall_b), .flush(flush_b), .fwd_a(fa_b),
    .fwd_b(fb_b), .mdu_busy(busy_b), .dbg_state(dbg_b));

  int n_vec = 0;
  int n_err = 0;
  int lsc[2]     = '{1, 3};
  int ld_rem[2]  = '{0, 0};   // load bubbles still owed after this cycle's stall
  int mdu_rem[2] = '{0, 0};   // cycles until HI/LO becomes valid

  function automatic logic hit(logic [AW-1:0] src, logic used, logic [AW-1:0] dst, logic we);
    return used && we && (dst != 0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_of(logic [AW-1:0] src);
    if (hit(src, 1'b1, mem_wr_reg, mem_reg_write)) return 2'b10;
    if (hit(src, 1'b1, wb_wr_reg, wb_reg_write)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    logic lh, raw, fl, es;
    logic [1:0] ea, eb;
    @(negedge clk);
    lh = ex_mem_to_reg && (hit(id_rs, id_uses_rs, ex_wr_reg, 1'b1) ||
                           hit(id_rt, id_uses_rt, ex_wr_reg, 1'b1));
`ifdef FORWARDING_EN
    raw = 1'b0;
    ea  = fwd_of(ex_rs);
    eb  = fwd_of(ex_rt);
`else
    raw = hit(id_rs, id_uses_rs, ex_wr_reg, ex_reg_write) || hit(id_rt, id_uses_rt, ex_wr_reg, ex_reg_write) ||
          hit(id_rs, id_uses_rs, mem_wr_reg, mem_reg_write) || hit(id_rt, id_uses_rt, mem_wr_reg, mem_reg_write);
    ea  = 2'b00;
    eb  = 2'b00;
`endif
    fl = ex_branch_taken || ex_jump;
    if (rst) begin
      ea = 2'b00;
      eb = 2'b00;
    end
    for (int k = 0; k < 2; k++) begin
      es = !rst && !fl && ((ld_rem[k] > 0) || lh || (id_uses_hilo && ((mdu_rem[k] > 0) || mdu_start)) || raw);
      chk($sformatf("stall_l%0d", lsc[k]), 8'(k == 0 ? stall_a : stall_b), 8'(es));
      chk($sformatf("flush_l%0d", lsc[k]), 8'(k == 0 ? flush_a : flush_b), 8'(!rst && fl));
      chk($sformatf("fwd_a_l%0d", lsc[k]), 8'(k == 0 ? fa_a : fa_b), 8'(ea));
      chk($sformatf("fwd_b_l%0d", lsc[k]), 8'(k == 0 ? fb_a : fb_b), 8'(eb));
      chk($sformatf("busy_l%0d", lsc[k]), 8'(k == 0 ? busy_a : busy_b), 8'(!rst && (mdu_rem[k] > 0)));
      chk($sformatf("waiting_l%0d", lsc[k]), 8'(k == 0 ? dbg_a : dbg_b), 8'(ld_rem[k] > 0));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ld_rem[k]  = 0;
        mdu_rem[k] = 0;
      end else begin
        if (fl)                ld_rem[k] = 0;
        else if (ld_rem[k] > 0) ld_rem[k] = ld_rem[k] - 1;
        else if (lh)            ld_rem[k] = lsc[k] - 1;
        if (mdu_start)          mdu_rem[k] = LAT;
        else if (mdu_rem[k] > 0) mdu_rem[k] = mdu_rem[k] - 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
    ex_rs = 0; ex_rt = 0; ex_wr_reg = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_branch_taken = 0; ex_jump = 0; mdu_start = 0;
    mem_wr_reg = 0; wb_wr_reg = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic load_use_r8();
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_wr_reg = 8; id_rs = 8; id_uses_rs = 1;
  endtask

  initial begin
    rst = 1; idle();
    step(); step();
    rst = 0;
    step();
    // load-use on r8, then the consumer in EX sees the load in MEM
    load_use_r8(); step();
    idle(); mem_wr_reg = 8; mem_reg_write = 1; ex_rs = 8; step();
    idle(); step(); step(); step();
    // load-use squashed by a taken branch, and by a jump
    load_use_r8(); ex_branch_taken = 1; step();
    idle(); step();
    load_use_r8(); ex_jump = 1; step();
    idle(); step();
    // mfhi waits on the MDU, with a restart mid-count
    mdu_start = 1; step();
    mdu_start = 0; id_uses_hilo = 1; step(); step();
    mdu_start = 1; step();
    mdu_start = 0; step(); step(); step(); step(); step();
    idle(); step();
    // MEM and WB both write r5; then writes to r0
    mem_wr_reg = 5; mem_reg_write = 1; wb_wr_reg = 5; wb_reg_write = 1; ex_rs = 5; ex_rt = 5; step();
    mem_wr_reg = 0; step();
    wb_wr_reg = 0; ex_rs = 0; ex_rt = 0; id_rs = 0; id_uses_rs = 1; step();
    idle(); wb_wr_reg = 6; wb_reg_write = 1; ex_rt = 6; step();
    // reset in the middle of a load wait with the MDU busy
    idle(); load_use_r8(); mdu_start = 1; step();
    idle(); id_uses_hilo = 1; rst = 1; step();
    rst = 0; step(); step();
    // back-to-back add/add on r3
    idle(); ex_reg_write = 1; ex_wr_reg = 3; id_rs = 3; id_uses_rs = 1; step();
    ex_reg_write = 0; ex_wr_reg = 0; mem_reg_write = 1; mem_wr_reg = 3; step();
    mem_reg_write = 0; mem_wr_reg = 0; wb_reg_write = 1; wb_wr_reg = 3; ex_rs = 3; step();
    idle(); step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 39) == 0);
      id_rs           = AW'($urandom_range(0, 7));
      id_rt           = AW'($urandom_range(0, 7));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_uses_hilo    = ($urandom_range(0, 2) == 0);
      ex_rs           = AW'($urandom_range(0, 7));
      ex_rt           = AW'($urandom_range(0, 7));
      ex_wr_reg       = AW'($urandom_range(0, 7));
      ex_reg_write    = 1'($urandom_range(0, 1));
      ex_mem_to_reg   = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_jump         = ($urandom_range(0, 15) == 0);
      mdu_start       = ($urandom_range(0, 9) == 0);
      mem_wr_reg      = AW'($urandom_range(0, 7));
      wb_wr_reg       = AW'($urandom_range(0, 7));
      mem_reg_write   = 1'($urandom_range(0, 1));
      wb_reg_write    = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0; idle(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
